// File: rtl/booth_seq_mult.sv
// Sequential signed multiplier, radix-4 Booth, one digit per clock, valid/ready on both sides.
// Optional macro BOOTH_SEQ_ACC_EN adds the acc_en port for multiply-accumulate operation.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef BOOTH_SEQ_ACC_EN
  input  logic               acc_en,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW     = 2 * WIDTH;
  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH:0]   b_ext_q;     // multiplier with the implicit b[-1]=0 appended
  logic [PW-1:0]    mcand_q;     // sign-extended multiplicand, pre-weighted by 4^i
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]       triplet;
  logic             bd_zero;
  logic             bd_shift;
  logic             bd_neg;
  logic [PW-1:0]    magnitude;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_d;

  // Zero/Shift/Negation decode of the current Booth triplet.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    triplet   = b_ext_q[2:0];
    bd_zero   = (triplet == 3'b000) || (triplet == 3'b111);
    bd_shift  = (triplet == 3'b011) || (triplet == 3'b100);
    bd_neg    = triplet[2];
    magnitude = bd_shift ? (mcand_q << 1) : mcand_q;
    pp        = '0;
    if (!bd_zero) pp = bd_neg ? -magnitude : magnitude;
    acc_d     = acc_q + pp;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      b_ext_q     <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            b_ext_q    <= {b, 1'b0};
            mcand_q    <= {{WIDTH{a[WIDTH-1]}}, a};
            cnt_q      <= '0;
`ifdef BOOTH_SEQ_ACC_EN
            acc_q      <= acc_en ? product_q : '0;
`else
            acc_q      <= '0;
`endif
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 2;
          b_ext_q <= b_ext_q >> 2;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_DIGIT) begin
            state_q     <= DONE;
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed corner cases plus random operands
// against a plain-arithmetic signed multiply(-accumulate) model.
module tb_booth_seq_mult;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             acc_en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    product;

  int n_cmp;
  int n_bad;
  logic signed [PW-1:0] model_prod;

  booth_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef BOOTH_SEQ_ACC_EN
    .acc_en    (acc_en),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one operation; leaves the DUT in DONE with out_valid high (out_ready held low).
  task automatic start_and_wait(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic acc, output int latency);
    logic signed [WIDTH-1:0] as;
    logic signed [WIDTH-1:0] bs;
    logic signed [PW-1:0]    p;
    logic                    use_acc;
    as = av;
    bs = bv;
    p  = as * bs;
`ifdef BOOTH_SEQ_ACC_EN
    use_acc = acc;
`else
    use_acc = 1'b0;
`endif
    model_prod = use_acc ? model_prod + p : p;
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    acc_en   = acc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    latency  = 0;
    while (!out_valid && latency < 20) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic do_op(input string tag, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic acc);
    int lat;
    start_and_wait(av, bv, acc, lat);
    check({tag, "_latency"}, lat, WIDTH / 2);
    @(negedge clk);
    check({tag, "_product"}, {16'd0, product}, {16'd0, model_prod});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [PW-1:0] held;
    n_cmp      = 0;
    n_bad      = 0;
    model_prod = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    acc_en     = 1'b0;
    a          = '0;
    b          = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    do_op("3x5", 8'd3, 8'd5, 1'b0);
    check("3x5_const", {16'd0, product}, 32'h000F);
    do_op("m128xm128", 8'h80, 8'h80, 1'b0);
    check("m128xm128_const", {16'd0, product}, 32'h4000);
    do_op("127xm128", 8'h7F, 8'h80, 1'b0);
    check("127xm128_const", {16'd0, product}, 32'hC080);
    do_op("m77x0", 8'hB3, 8'h00, 1'b0);
    check("m77x0_const", {16'd0, product}, 32'h0000);
    do_op("1xm1", 8'h01, 8'hFF, 1'b0);
    check("1xm1_const", {16'd0, product}, 32'hFFFF);

    // Back-pressure in DONE while a new operand pair is offered.
    start_and_wait(8'd7, 8'hF7, 1'b0, lat);
    check("stall_latency", lat, WIDTH / 2);
    held = model_prod;
    a = 8'd99;
    b = 8'd55;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_product", {16'd0, product}, {16'd0, held});
      check("stall_flags", {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall_release", {30'd0, out_valid, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("idle_hold", {16'd0, product}, {16'd0, held});

    // Reset pulsed during the second RUN cycle.
    @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_prod = '0;
    repeat (6) @(negedge clk);
    check("abort_no_result", {31'd0, out_valid}, 32'd0);
    do_op("2x3", 8'd2, 8'd3, 1'b0);
    check("2x3_const", {16'd0, product}, 32'd6);

`ifdef BOOTH_SEQ_ACC_EN
    do_op("mac_10x10", 8'd10, 8'd10, 1'b0);
    check("mac_10x10_const", {16'd0, product}, 32'd100);
    do_op("mac_2x3", 8'd2, 8'd3, 1'b1);
    check("mac_2x3_const", {16'd0, product}, 32'd106);
    do_op("mac_4x4", 8'd4, 8'd4, 1'b0);
    check("mac_4x4_const", {16'd0, product}, 32'd16);
`endif

    for (int i = 0; i < 40; i++) begin
      do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8; operand width; even and >= 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, operand pair is presented.
REQ-005 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-006 SHALL have port a, input, WIDTH, signed multiplicand.
REQ-007 SHALL have port b, input, WIDTH, signed multiplier (Booth-recoded).
REQ-008 SHALL have port out_valid, output, 1, product is available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the product.
REQ-010 SHALL have port product, output, 2*WIDTH, signed result.
REQ-011 SHALL have port acc_en, input, 1, accumulate request, sampled with operands; present only when BOOTH_SEQ_ACC_EN is defined.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 SHALL move IDLE->RUN on the edge where in_valid&in_ready; on that edge it latches a, b and clears the iteration counter and partial accumulator.
REQ-014 SHALL, in RUN, process one radix-4 Booth digit per cycle: digit i (0..WIDTH/2-1) uses triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
REQ-015 SHALL decode each triplet as follows: 000 and 111 give 0; 001 and 010 give +a; 011 gives +2a; 100 gives -2a; 101 and 110 give -a. This is the Zero/Shift/Negation encoding.
REQ-016 SHALL form each partial product by sign-extending to 2*WIDTH bits, applying the shift and two's-complement negation, and weighting it by 2^(2i); accumulation is modulo 2^(2*WIDTH).
REQ-017 SHALL move RUN->DONE on the edge that processes digit WIDTH/2-1; product and out_valid update on that edge.
REQ-018 SHALL make out_valid rise exactly WIDTH/2 cycles after the accept edge (4 for WIDTH=8).
REQ-019 SHALL hold product and out_valid stable in DONE until out_ready=1; DONE->IDLE on the edge where out_valid&out_ready.
REQ-020 SHALL ignore in_valid in RUN and DONE; no operand overlap; minimum initiation interval is WIDTH/2+2 cycles.
REQ-021 SHALL keep product at its last value in IDLE; only a completed RUN updates it.
REQ-022 SHALL produce exact signed results at the extremes, e.g. (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2) with no overflow.

Reset
REQ-023 SHALL, while rst_n=0, force: state IDLE, in_ready=1 once released, out_valid=0, product=0, counter=0, partial accumulator=0.
REQ-024 SHALL, when rst_n is asserted mid-RUN or in DONE, abort the operation immediately; no partial result is ever presented.

Configuration
REQ-025 SHALL support macro BOOTH_SEQ_ACC_EN.
  - Defined: port acc_en exists; if acc_en=1 at acceptance, the partial accumulator is initialised with the current product instead of 0, giving MAC behaviour with wrap modulo 2^(2*WIDTH); if acc_en=0, it is cleared.
  - Undefined: no acc_en port; every operation starts from 0.

Verification
REQ-026 SHALL verify: WIDTH=8, a=3, b=5 -> out_valid 4 cycles after accept, product=16'h000F.
REQ-027 SHALL verify: a=-128, b=-128 -> product=16'h4000; then a=127, b=-128 -> product=16'hC080 (-16256).
REQ-028 SHALL verify: a=-77, b=0 -> product=0; and a=1, b=-1 -> product=16'hFFFF.
REQ-029 SHALL verify: out_ready=0 for 6 cycles in DONE -> product and out_valid stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-030 SHALL verify: rst_n pulsed low in the 2nd RUN cycle -> out_valid=0 and product=0 asynchronously; the next accepted 2*3 yields 6.
REQ-031 SHALL verify, with BOOTH_SEQ_ACC_EN: 10*10 with acc_en=0 -> 100; then 2*3 with acc_en=1 -> 106; then 4*4 with acc_en=0 -> 16.
